gcd_ctrl: RTL and testbench
===========================

Name: gcd_ctrl

Overview:
- FSM controller for the subtractive GCD datapath.
- Accepts a start request and two operands over a valid/ready handshake.
- Drives datapath load/select lines (lda, ldb, sel1, sel2, sel_in), consumes comparator status (lt, gt, eq), and signals completion.
- Result is read by the consumer from the datapath A register while done=1.

Parameters:
- ITER_W, 16, width of iteration counter iter_count.
- MAX_ITER, 65535, watchdog iteration limit (used only with GCD_WATCHDOG_EN); must fit in ITER_W bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- start  in  1  begin new operation; sampled in IDLE, DONE, ERR.
- in_valid  in  1  data_in on datapath bus holds a valid operand.
- in_ready  out  1  controller accepting an operand this cycle.
- lt  in  1  datapath A<B.
- gt  in  1  datapath A>B.
- eq  in  1  datapath A==B.
- lda  out  1  load datapath A register.
- ldb  out  1  load datapath B register.
- sel1  out  1  subtractor minuend select: 0=A, 1=B.
- sel2  out  1  subtractor subtrahend select: 0=A, 1=B.
- sel_in  out  1  bus select: 0=subtractor, 1=data_in.
- busy  out  1  operation in progress.
- done  out  1  result valid in A; level, held in DONE.
- err  out  1  watchdog abort; constant 0 without macro.
- iter_count  out  ITER_W  subtract cycles in current/last operation.

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active low; it clears state to IDLE and drives every output to 0, including iter_count.
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE, ERR (ERR exists only with the macro).
- IDLE: start=1 -> LOAD_A; iter_count cleared to 0 on the same edge.
- LOAD_A:
  - in_ready=1, sel_in=1, lda=in_valid.
  - in_valid=1 -> LOAD_B; otherwise stay (stall, no load).
- LOAD_B:
  - in_ready=1, sel_in=1, ldb=in_valid.
  - in_valid=1 -> RUN.
- RUN: outputs are Mealy on the status inputs, which reflect registers loaded on the previous edge.
  - eq=1 -> DONE; no loads.
  - gt=1: lda=1, sel1=0, sel2=1, sel_in=0 (A<=A-B); iter_count+1.
  - lt=1: ldb=1, sel1=1, sel2=0, sel_in=0 (B<=B-A); iter_count+1.
  - Exactly one subtraction per cycle.
- DONE: done=1, busy=0. start=1 -> LOAD_A with iter_count cleared; otherwise hold.
- busy=1 in LOAD_A, LOAD_B, RUN.
- In all states not listed as driving a signal, lda=ldb=0 and sel1=sel2=sel_in=0.
- start while busy is ignored.
- iter_count saturates at all-ones; it never wraps.
- Latency:
  - Start to first operand accept is 1 cycle.
  - Equal operands: done=1 two cycles after B accepted (one RUN cycle, then DONE).
  - N subtractions: done N+1 cycles after the RUN entry edge.
- Illegal status (none or more than one of lt/gt/eq high) in RUN: no load; stay in RUN.
- Reset asserted mid-operation aborts immediately. Datapath register contents are don't-care.

Optional Feature:
- Macro GCD_WATCHDOG_EN.
- With macro: in RUN, if iter_count==MAX_ITER and eq=0 -> ERR.
  - ERR: err=1, busy=0, no loads. start=1 -> LOAD_A, err cleared.
  - Guards zero operands (A or B = 0 never converges).
- Without macro: no ERR state, err tied 0, and RUN runs until eq.

Decomposition:
- Package gcd_pkg holds:
  - state enum (gcd_state_t).
  - select constants SEL_A=0, SEL_B=1, SEL_IN_SUB=0, SEL_IN_DATA=1.
- Controller is a single module. The saturating counter may be split into sub-module gcd_iter_cnt; this is optional.

Test Plan:
- Operands 48, 18 -> A sequence 30, 12, 12, 6 with B 18, 18, 6, 6; done=1 with A=6, iter_count=4, and done 5 cycles after RUN entry.
- Operands 7, 7 -> no lda/ldb in RUN; done=1 two cycles after B accepted; iter_count=0.
- Operands 13, 1 -> A result 1, iter_count=12. Hold in_valid=0 for 3 cycles in LOAD_B -> in_ready stays 1, ldb=0 until valid, and the result is unchanged.
- With GCD_WATCHDOG_EN and MAX_ITER=16, operands 5, 0 -> err=1 after iter_count=16, done stays 0. start -> err clears and the next operation runs normally.
- Assert rst_n=0 mid-RUN of 48, 18 -> all outputs 0 immediately (asynchronously). Release, then start with 9, 6 -> result 3.
- start pulses during LOAD_B and RUN -> ignored. start in DONE -> immediate new LOAD_A, iter_count reset to 0.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types, constants and helpers for the subtractive GCD
// controller.
//   gcd_state_t : controller state encoding (ERR only with GCD_WATCHDOG_EN)
//   SEL_*       : encodings of the datapath select lines
//   gcd_cmp_t   : decoded comparator status, with CMP_BAD for illegal input
// Build option: GCD_WATCHDOG_EN adds the ST_ERR state.
package gcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
`ifdef GCD_WATCHDOG_EN
    ,
    ST_ERR    = 3'd5
`endif
  } gcd_state_t;

  // Subtractor operand selects (sel1 = minuend, sel2 = subtrahend).
  localparam logic SEL_A       = 1'b0;
  localparam logic SEL_B       = 1'b1;
  // Register input bus select.
  localparam logic SEL_IN_SUB  = 1'b0;
  localparam logic SEL_IN_DATA = 1'b1;

  typedef enum logic [1:0] {
    CMP_BAD = 2'd0,
    CMP_LT  = 2'd1,
    CMP_GT  = 2'd2,
    CMP_EQ  = 2'd3
  } gcd_cmp_t;

  // Only a one-hot status is trusted; anything else is treated as illegal.
  function automatic gcd_cmp_t decode_cmp(input logic lt, input logic gt,
                                          input logic eq);
    gcd_cmp_t res;
    case ({lt, gt, eq})
      3'b100:  res = CMP_LT;
      3'b010:  res = CMP_GT;
      3'b001:  res = CMP_EQ;
      default: res = CMP_BAD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gcd_iter_cnt.sv
// gcd_iter_cnt: saturating iteration counter for the GCD controller.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   clr        : synchronous clear, wins over inc
//   inc        : count one subtraction; holds at all-ones instead of wrapping
//   count      : current value
module gcd_iter_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  // Count register: clear has priority, increment saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != ALL_ONES)) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: FSM controller for a subtractive GCD datapath.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin an operation (honoured in IDLE, DONE, ERR)
//   in_valid/in_ready : operand handshake on the datapath input bus
//   lt, gt, eq        : datapath comparator status (A vs B)
//   lda, ldb          : load strobes for datapath A / B registers
//   sel1, sel2        : subtractor minuend / subtrahend select (0=A, 1=B)
//   sel_in            : register input select (0=subtractor, 1=data_in)
//   busy, done, err   : status; result is in datapath A while done=1
//   iter_count        : subtractions in the current / last operation
// Build option: define GCD_WATCHDOG_EN to abort to ERR once iter_count
// reaches MAX_ITER without convergence; otherwise err is tied low.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int ITER_W   = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  output logic              lda,
  output logic              ldb,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  gcd_state_t state;
  gcd_cmp_t   cmp;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       run_ok;

  // A watchdog limit the counter can never reach is a build error.
  if ($clog2(MAX_ITER + 1) > ITER_W) begin : g_max_iter_check
    $error("gcd_ctrl: MAX_ITER does not fit in ITER_W bits");
  end

  assign cmp = decode_cmp(lt, gt, eq);

`ifdef GCD_WATCHDOG_EN
  logic err_flag;
  logic wd_trip;
  // Abort when the limit is reached and A and B are still not equal.
  assign wd_trip = (state == ST_RUN) && (iter_count == ITER_W'(MAX_ITER)) && !eq;
  assign run_ok  = !wd_trip;
  assign err     = err_flag;
`else
  assign run_ok  = 1'b1;
  assign err     = 1'b0;
`endif

  // Datapath strobes and counter control; RUN is Mealy on the status inputs.
  always_comb begin
    in_ready = 1'b0;
    lda      = 1'b0;
    ldb      = 1'b0;
    sel1     = SEL_A;
    sel2     = SEL_A;
    sel_in   = SEL_IN_SUB;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = start;
      end
      ST_LOAD_A: begin
        in_ready = 1'b1;
        sel_in   = SEL_IN_DATA;
        lda      = in_valid;
      end
      ST_LOAD_B: begin
        in_ready = 1'b1;
        sel_in   = SEL_IN_DATA;
        ldb      = in_valid;
      end
      ST_RUN: begin
        // A tripping watchdog suppresses the subtraction on the abort cycle.
        if (run_ok) begin
          case (cmp)
            CMP_GT: begin
              lda     = 1'b1;
              sel1    = SEL_A;
              sel2    = SEL_B;
              cnt_inc = 1'b1;
            end
            CMP_LT: begin
              ldb     = 1'b1;
              sel1    = SEL_B;
              sel2    = SEL_A;
              cnt_inc = 1'b1;
            end
            default: begin
              cnt_inc = 1'b0;
            end
          endcase
        end else begin
          cnt_inc = 1'b0;
        end
      end
      ST_DONE: begin
        cnt_clr = start;
      end
`ifdef GCD_WATCHDOG_EN
      ST_ERR: begin
        cnt_clr = start;
      end
`endif
      default: begin
        cnt_clr = 1'b0;
      end
    endcase
  end

  // Controller state with registered busy/done/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef GCD_WATCHDOG_EN
      err_flag <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD_A;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD_A: begin
          if (in_valid) begin
            state <= ST_LOAD_B;
          end else begin
            state <= ST_LOAD_A;
          end
        end
        ST_LOAD_B: begin
          if (in_valid) begin
            state <= ST_RUN;
          end else begin
            state <= ST_LOAD_B;
          end
        end
        ST_RUN: begin
`ifdef GCD_WATCHDOG_EN
          if (wd_trip) begin
            state    <= ST_ERR;
            busy     <= 1'b0;
            err_flag <= 1'b1;
          end else
`endif
          if (cmp == CMP_EQ) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_LOAD_A;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= ST_DONE;
          end
        end
`ifdef GCD_WATCHDOG_EN
        ST_ERR: begin
          if (start) begin
            state    <= ST_LOAD_A;
            busy     <= 1'b1;
            err_flag <= 1'b0;
          end else begin
            state    <= ST_ERR;
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
`ifdef GCD_WATCHDOG_EN
          err_flag <= 1'b0;
`endif
        end
      endcase
    end
  end

  gcd_iter_cnt #(
    .W     (ITER_W)
  ) u_iter_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (iter_count)
  );

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: self-checking bench for gcd_ctrl. A behavioural datapath
// (A/B registers, subtractor, comparator) closes the loop around the
// controller; expected results come from a Euclid-division reference model.
module tb_gcd_ctrl;

  localparam int IW   = 6;
  localparam int MAXI = 16;
  localparam int SAT  = (1 << IW) - 1;
`ifdef GCD_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, lt, gt, eq, lda, ldb, sel1, sel2, sel_in;
  logic          busy, done, err;
  logic [IW-1:0] iter_count;
  logic [15:0]   data_in = 16'd0;
  logic [15:0]   a_reg = 16'd0;
  logic [15:0]   b_reg = 16'd0;
  logic [15:0]   sub;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gcd_ctrl #(.ITER_W(IW), .MAX_ITER(MAXI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .lt(lt), .gt(gt), .eq(eq), .lda(lda), .ldb(ldb),
    .sel1(sel1), .sel2(sel2), .sel_in(sel_in), .busy(busy), .done(done),
    .err(err), .iter_count(iter_count)
  );

  // Datapath environment driven by the controller's strobes.
  assign sub = (sel1 ? b_reg : a_reg) - (sel2 ? b_reg : a_reg);
  assign lt  = a_reg < b_reg;
  assign gt  = a_reg > b_reg;
  assign eq  = a_reg == b_reg;
  always @(posedge clk) begin
    if (lda) a_reg <= sel_in ? data_in : sub;
    if (ldb) b_reg <= sel_in ? data_in : sub;
  end

  // Reference: gcd by Euclid; subtraction count = sum of quotients - 1.
  function automatic void model(input int unsigned a, input int unsigned b,
                                output int unsigned g, output int unsigned n);
    int unsigned x, y, r, qs;
    if (a == 0 || b == 0) begin
      g = 0;
      n = 32'hFFFF_FFFF;
      return;
    end
    x = a; y = b; qs = 0;
    while (y != 0) begin
      qs += x / y;
      r = x % y;
      x = y;
      y = r;
    end
    g = x;
    n = qs - 1;
  endfunction

  // Expected outcome derived from the reference subtraction count.
  function automatic void expect_op(input int unsigned n, output bit e_err,
                                    output int e_iter, output int e_cyc,
                                    output int e_loads);
    e_err   = WD && (n > MAXI);
    e_iter  = e_err ? MAXI : ((n > SAT) ? SAT : int'(n));
    e_cyc   = e_err ? MAXI + 1 : int'(n) + 1;
    e_loads = e_err ? MAXI : int'(n);
  endfunction

  // One full operation through the handshake; returns observations only.
  task automatic do_op(input int unsigned a, input int unsigned b,
                       input int stall_b, input bit poke,
                       output int res, output int iter, output bit fdone,
                       output bit ferr, output bit fbusy, output int cyc,
                       output int loads, output bit rdy_a, output int iter_ld,
                       output int stall_bad, output bit tmo);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; data_in = 16'(a);
    #1;
    rdy_a = in_ready;
    iter_ld = int'(iter_count);
    @(negedge clk);
    in_valid = 1'b0; data_in = 16'hBEEF; start = poke;
    stall_bad = 0;
    for (int i = 0; i < stall_b; i++) begin
      #1;
      if (in_ready !== 1'b1 || ldb !== 1'b0) stall_bad++;
      @(negedge clk);
    end
    in_valid = 1'b1; data_in = 16'(b);
    @(negedge clk);
    in_valid = 1'b0; data_in = 16'hBEEF; start = 1'b0;
    cyc = 0; loads = 0; tmo = 1'b0;
    while (1'b1) begin
      #1;
      if (done || err) break;
      loads += int'(lda) + int'(ldb);
      if (cyc >= 300) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
      start = poke & cyc[0];
    end
    start = 1'b0;
    res = int'(a_reg); iter = int'(iter_count);
    fdone = done; ferr = err; fbusy = busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({in_ready, lda, ldb, sel1, sel2, sel_in, busy, done, err} !== 9'd0 ||
        iter_count !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b iter=%0d want all 0",
               {in_ready, lda, ldb, sel1, sel2, sel_in, busy, done, err}, iter_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed operand sets, including the LOAD_B stall and saturation cases.
  task automatic test_fixed;
    int unsigned ta[4] = '{48, 7, 13, 70};
    int unsigned tb[4] = '{18, 7, 1, 1};
    int          ts[4] = '{0, 0, 3, 0};
    int unsigned g, n;
    int res, iter, cyc, loads, iter_ld, stall_bad, e_iter, e_cyc, e_loads;
    bit fdone, ferr, fbusy, rdy_a, tmo, e_err;
    for (int k = 0; k < 4; k++) begin
      do_op(ta[k], tb[k], ts[k], 1'b0, res, iter, fdone, ferr, fbusy, cyc,
            loads, rdy_a, iter_ld, stall_bad, tmo);
      model(ta[k], tb[k], g, n);
      expect_op(n, e_err, e_iter, e_cyc, e_loads);
      vectors++;
      if (tmo) begin miscompares++; $display("FAIL fixed_timeout op%0d: no done after %0d cycles", k, cyc); end
      vectors++;
      if (fdone !== !e_err || ferr !== e_err) begin
        miscompares++; $display("FAIL fixed_status op%0d: done=%b err=%b want done=%b err=%b", k, fdone, ferr, !e_err, e_err);
      end
      vectors++;
      if (!e_err && res != int'(g)) begin miscompares++; $display("FAIL fixed_result op%0d: got %0d want %0d", k, res, g); end
      vectors++;
      if (iter != e_iter) begin miscompares++; $display("FAIL fixed_iter op%0d: got %0d want %0d", k, iter, e_iter); end
      vectors++;
      if (cyc != e_cyc) begin miscompares++; $display("FAIL fixed_latency op%0d: got %0d want %0d", k, cyc, e_cyc); end
      vectors++;
      if (loads != e_loads) begin miscompares++; $display("FAIL fixed_loads op%0d: got %0d want %0d", k, loads, e_loads); end
      vectors++;
      if (fbusy !== 1'b0 || rdy_a !== 1'b1) begin
        miscompares++; $display("FAIL fixed_busy_ready op%0d: busy=%b ready=%b want 0/1", k, fbusy, rdy_a);
      end
      vectors++;
      if (stall_bad != 0) begin miscompares++; $display("FAIL fixed_stall op%0d: %0d bad stall cycles want 0", k, stall_bad); end
      @(negedge clk);
      #1;
      vectors++;
      if (done !== !e_err || int'(iter_count) != e_iter || int'(a_reg) != res) begin
        miscompares++; $display("FAIL fixed_hold op%0d: done=%b iter=%0d A=%0d want %b/%0d/%0d", k, done, iter_count, a_reg, !e_err, e_iter, res);
      end
    end
  endtask

  // start pulses in LOAD_B and RUN must not disturb the operation.
  task automatic test_start_ignored;
    int res, iter, cyc, loads, iter_ld, stall_bad;
    bit fdone, ferr, fbusy, rdy_a, tmo;
    do_op(48, 18, 2, 1'b1, res, iter, fdone, ferr, fbusy, cyc, loads, rdy_a,
          iter_ld, stall_bad, tmo);
    vectors++;
    if (tmo || fdone !== 1'b1 || res != 6 || iter != 4 || cyc != 5 || loads != 4) begin
      miscompares++;
      $display("FAIL start_ignored: done=%b A=%0d iter=%0d cyc=%0d loads=%0d want 1/6/4/5/4", fdone, res, iter, cyc, loads);
    end
  endtask

  // start in DONE goes straight to LOAD_A with the counter cleared.
  task automatic test_back_to_back;
    int res, iter, cyc, loads, iter_ld, stall_bad;
    bit fdone, ferr, fbusy, rdy_a, tmo;
    do_op(48, 18, 0, 1'b0, res, iter, fdone, ferr, fbusy, cyc, loads, rdy_a,
          iter_ld, stall_bad, tmo);
    do_op(13, 1, 0, 1'b0, res, iter, fdone, ferr, fbusy, cyc, loads, rdy_a,
          iter_ld, stall_bad, tmo);
    vectors++;
    if (iter_ld != 0 || rdy_a !== 1'b1) begin
      miscompares++; $display("FAIL b2b_restart: iter=%0d ready=%b want 0/1", iter_ld, rdy_a);
    end
    vectors++;
    if (tmo || fdone !== 1'b1 || res != 1 || iter != 12) begin
      miscompares++; $display("FAIL b2b_result: done=%b A=%0d iter=%0d want 1/1/12", fdone, res, iter);
    end
  endtask

  task automatic test_midrun_reset;
    int res, iter, cyc, loads, iter_ld, stall_bad;
    bit fdone, ferr, fbusy, rdy_a, tmo, busy_before;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; data_in = 16'd48;
    @(negedge clk); data_in = 16'd18;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    busy_before = busy;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy_before !== 1'b1) begin miscompares++; $display("FAIL midrun_setup: busy=%b want 1", busy_before); end
    vectors++;
    if ({in_ready, lda, ldb, sel1, sel2, sel_in, busy, done, err} !== 9'd0 ||
        iter_count !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got %b iter=%0d want all 0",
               {in_ready, lda, ldb, sel1, sel2, sel_in, busy, done, err}, iter_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(9, 6, 0, 1'b0, res, iter, fdone, ferr, fbusy, cyc, loads, rdy_a,
          iter_ld, stall_bad, tmo);
    vectors++;
    if (tmo || fdone !== 1'b1 || res != 3 || iter != 2) begin
      miscompares++; $display("FAIL midrun_recover: done=%b A=%0d iter=%0d want 1/3/2", fdone, res, iter);
    end
  endtask

  task automatic test_random;
    int unsigned a, b, g, n;
    int res, iter, cyc, loads, iter_ld, stall_bad, e_iter, e_cyc, e_loads;
    bit fdone, ferr, fbusy, rdy_a, tmo, e_err;
    for (int k = 0; k < 24; k++) begin
      a = $urandom_range(60, 1);
      b = $urandom_range(60, 1);
      do_op(a, b, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), res,
            iter, fdone, ferr, fbusy, cyc, loads, rdy_a, iter_ld, stall_bad, tmo);
      model(a, b, g, n);
      expect_op(n, e_err, e_iter, e_cyc, e_loads);
      vectors++;
      if (tmo || fdone !== !e_err || ferr !== e_err || (!e_err && res != int'(g))) begin
        miscompares++;
        $display("FAIL rand_result %0d,%0d: done=%b err=%b A=%0d want %b/%b/%0d", a, b, fdone, ferr, res, !e_err, e_err, g);
      end
      vectors++;
      if (iter != e_iter || cyc != e_cyc || loads != e_loads || stall_bad != 0) begin
        miscompares++;
        $display("FAIL rand_timing %0d,%0d: iter=%0d cyc=%0d loads=%0d stall=%0d want %0d/%0d/%0d/0", a, b, iter, cyc, loads, stall_bad, e_iter, e_cyc, e_loads);
      end
    end
  endtask

`ifdef GCD_WATCHDOG_EN
  // Zero operand never converges: watchdog aborts, then a new op recovers.
  task automatic test_watchdog;
    int res, iter, cyc, loads, iter_ld, stall_bad;
    bit fdone, ferr, fbusy, rdy_a, tmo;
    do_op(5, 0, 0, 1'b0, res, iter, fdone, ferr, fbusy, cyc, loads, rdy_a,
          iter_ld, stall_bad, tmo);
    vectors++;
    if (tmo || ferr !== 1'b1 || fdone !== 1'b0 || fbusy !== 1'b0 || iter != MAXI || cyc != MAXI + 1) begin
      miscompares++;
      $display("FAIL wd_abort: err=%b done=%b busy=%b iter=%0d cyc=%0d want 1/0/0/%0d/%0d", ferr, fdone, fbusy, iter, cyc, MAXI, MAXI + 1);
    end
    do_op(9, 6, 0, 1'b0, res, iter, fdone, ferr, fbusy, cyc, loads, rdy_a,
          iter_ld, stall_bad, tmo);
    vectors++;
    if (tmo || ferr !== 1'b0 || fdone !== 1'b1 || res != 3 || iter != 2 || iter_ld != 0) begin
      miscompares++;
      $display("FAIL wd_recover: err=%b done=%b A=%0d iter=%0d want 0/1/3/2", ferr, fdone, res, iter);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_start_ignored();
    test_back_to_back();
    test_midrun_reset();
    test_random();
`ifdef GCD_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
